// File: rtl/loop_fsm_pkg.sv
// Shared state encodings and the per-channel next-state rule for loop_fsm_param.
package loop_fsm_pkg;

   // Fixed states of the walk; held 16 bits wide so any legal W can use them.
   localparam logic [15:0] S0  = 16'd0;
   localparam logic [15:0] S1  = 16'd1;
   localparam logic [15:0] S2  = 16'd2;
   localparam logic [15:0] S5  = 16'd5;
   localparam logic [15:0] S6  = 16'd6;
   localparam logic [15:0] S7  = 16'd7;
   localparam logic [15:0] S8  = 16'd8;
   localparam logic [15:0] S10 = 16'd10;

   // Next state of one channel with en=1 and no clear. Works on a 16-bit
   // zero-extended state; w selects which top two codes redirect to tgt.
   function automatic logic [15:0] next_state(input logic [15:0] x,
                                              input logic        i,
                                              input logic        cnt_at_max,
                                              input logic [15:0] tgt,
                                              input int unsigned w);
      logic [15:0] ones;
      ones       = 16'((17'd1 << w) - 17'd1);
      next_state = x;
      if (x == tgt)
         next_state = tgt;
      else if ((x == ones) || (x == (ones - 16'd1)))
         next_state = tgt;
      else begin
         case (x)
            S0:      next_state = S8;
            S8:      next_state = S10;
            S10:     next_state = S1;
            S1:      next_state = S2;
            S2:      next_state = i ? S5 : S6;
            S6:      next_state = S7;
            S7:      next_state = S5;
            S5:      next_state = (cnt_at_max && i) ? tgt : S1;
            default: next_state = x;
         endcase
      end
   endfunction

endpackage

// File: rtl/loop_fsm_chan.sv
// One channel of loop_fsm_param: state, loop counter, sticky hit flag, predicates.
module loop_fsm_chan #(
   parameter int unsigned W        = 4,
   parameter int unsigned TGT      = 9,
   parameter int unsigned THR      = 2,
   parameter int unsigned LOOP_MAX = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic i,
   input  logic clr,
   output logic z1,
   output logic z2,
   output logic z3,
   output logic hit
);
   import loop_fsm_pkg::*;

   // LOOP_MAX=0 still needs a one-bit counter that simply stays at zero.
   localparam int unsigned    CW      = (LOOP_MAX > 0) ? $clog2(LOOP_MAX + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(LOOP_MAX);

   logic [W-1:0]  r_x;
   logic [CW-1:0] r_cnt;
   logic          r_hit;

   logic [15:0]   w_nx;
   logic          w_at_max;
   logic          w_at5;
   logic          w_at_tgt;
   logic          w_esc;
   logic          w_unused_nx;

   assign w_at_max    = (r_cnt == CNT_MAX);
   assign w_at5       = (r_x == W'(S5));
   assign w_at_tgt    = (r_x == W'(TGT));
   assign w_esc       = w_at5 & w_at_max & i;
   assign w_nx        = next_state(16'(r_x), i, w_at_max, 16'(TGT), W);
   assign w_unused_nx = ^w_nx;

   // State, loop count and hit: reset, then clear, then stall, then step.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_x   <= '0;
         r_cnt <= '0;
         r_hit <= 1'b0;
      end else if (clr) begin
         r_x   <= '0;
         r_cnt <= '0;
      end else if (en) begin
         r_x   <= w_nx[W-1:0];
         r_hit <= r_hit | w_at_tgt;
         if (w_esc)
            r_cnt <= '0;
         else if (w_at5 && !w_at_max)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   assign z1  = r_x[3] & r_x[0];
   assign z2  = w_at_tgt;
   assign z3  = (32'(r_x) > THR);
   assign hit = r_hit;

endmodule

// File: rtl/loop_fsm_param.sv
// Multi-channel loop-state FSM: CH independent channels plus aggregate target flags.
module loop_fsm_param #(
   parameter int unsigned W        = 4,
   parameter int unsigned CH       = 2,
   parameter int unsigned TGT      = 9,
   parameter int unsigned THR      = 2,
   parameter int unsigned LOOP_MAX = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [CH-1:0] i,
   input  logic [CH-1:0] clr,
   output logic [CH-1:0] z1,
   output logic [CH-1:0] z2,
   output logic [CH-1:0] z3,
   output logic [CH-1:0] hit,
   output logic          all_tgt,
   output logic          any_tgt
);

   for (genvar c = 0; c < CH; c++) begin : g_ch
      loop_fsm_chan #(
         .W        (W),
         .TGT      (TGT),
         .THR      (THR),
         .LOOP_MAX (LOOP_MAX)
      ) u_chan (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .i     (i[c]),
         .clr   (clr[c]),
         .z1    (z1[c]),
         .z2    (z2[c]),
         .z3    (z3[c]),
         .hit   (hit[c])
      );
   end

   assign all_tgt = &z2;
   assign any_tgt = |z2;

endmodule

// File: tb/tb_loop_fsm_param.sv
// Bench for loop_fsm_param: directed timing checks and randomized traffic
// against a per-channel behavioural model, on a default and a LOOP_MAX=0 instance.
module tb_loop_fsm_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [1:0] i = '0;
   logic [1:0] clr = '0;

   logic [1:0] z1, z2, z3, hit;
   logic       all_tgt, any_tgt;
   logic [0:0] b_z1, b_z2, b_z3, b_hit;
   logic       b_all, b_any;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: channels 0,1 belong to dut, channel 2 to dut_b.
   int m_x[3];
   int m_cnt[3];
   int m_hit[3];
   int p_tgt[3]  = '{9, 9, 33};
   int p_lmax[3] = '{2, 2, 0};
   int p_w[3]    = '{4, 4, 6};
   int succ[int];

   always #5 clk = ~clk;

   loop_fsm_param #(.W(4), .CH(2), .TGT(9), .THR(2), .LOOP_MAX(2)) dut (
      .clk(clk), .reset(reset), .en(en), .i(i), .clr(clr),
      .z1(z1), .z2(z2), .z3(z3), .hit(hit),
      .all_tgt(all_tgt), .any_tgt(any_tgt)
   );

   loop_fsm_param #(.W(6), .CH(1), .TGT(33), .THR(2), .LOOP_MAX(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .i(i[0:0]), .clr(clr[0:0]),
      .z1(b_z1), .z2(b_z2), .z3(b_z3), .hit(b_hit),
      .all_tgt(b_all), .any_tgt(b_any)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One posedge of one channel, from the rules: reset > clear > stall > step.
   task automatic model_chan(input int c, input bit r, input bit e, input bit iv, input bit cv);
      int x;
      x = m_x[c];
      if (!r) begin
         m_x[c] = 0; m_cnt[c] = 0; m_hit[c] = 0;
      end else if (cv) begin
         m_x[c] = 0; m_cnt[c] = 0;
      end else if (e) begin
         if (x == p_tgt[c]) m_hit[c] = 1;
         if (x == p_tgt[c])
            m_x[c] = x;
         else if (x == 2)
            m_x[c] = iv ? 5 : 6;
         else if (x == 5) begin
            if (m_cnt[c] == p_lmax[c] && iv) begin
               m_x[c] = p_tgt[c]; m_cnt[c] = 0;
            end else begin
               m_x[c] = 1;
               if (m_cnt[c] < p_lmax[c]) m_cnt[c]++;
            end
         end else if (succ.exists(x))
            m_x[c] = succ[x];
         else if (x >= (1 << p_w[c]) - 2)
            m_x[c] = p_tgt[c];
      end
   endtask

   task automatic step(input bit r, input bit e, input logic [1:0] iv, input logic [1:0] cv);
      logic [1:0] ez1, ez2, ez3, eh;
      reset = r; en = e; i = iv; clr = cv;
      @(posedge clk);
      #1;
      model_chan(0, r, e, iv[0], cv[0]);
      model_chan(1, r, e, iv[1], cv[1]);
      model_chan(2, r, e, iv[0], cv[0]);
      for (int c = 0; c < 2; c++) begin
         ez1[c] = ((m_x[c] >> 3) & 1) == 1 && (m_x[c] & 1) == 1;
         ez2[c] = (m_x[c] == p_tgt[c]);
         ez3[c] = (m_x[c] > 2);
         eh[c]  = (m_hit[c] != 0);
      end
      chk("z1", 32'(z1), 32'(ez1));
      chk("z2", 32'(z2), 32'(ez2));
      chk("z3", 32'(z3), 32'(ez3));
      chk("hit", 32'(hit), 32'(eh));
      chk("all_tgt", 32'(all_tgt), 32'(ez2 == 2'b11));
      chk("any_tgt", 32'(any_tgt), 32'(ez2 != 2'b00));
      chk("b_z1", 32'(b_z1), 32'(((m_x[2] >> 3) & 1) == 1 && (m_x[2] & 1) == 1));
      chk("b_z2", 32'(b_z2), 32'(m_x[2] == p_tgt[2]));
      chk("b_z3", 32'(b_z3), 32'(m_x[2] > 2));
      chk("b_hit", 32'(b_hit), 32'(m_hit[2] != 0));
   endtask

   initial begin
      int first, bfirst, firstany, sawall;
      logic [1:0] rc;
      succ[0] = 8; succ[8] = 10; succ[10] = 1; succ[1] = 2; succ[6] = 7; succ[7] = 5;
      for (int c = 0; c < 3; c++) begin
         m_x[c] = 0; m_cnt[c] = 0; m_hit[c] = 0;
      end

      // Reset, then both channels walk straight to the target.
      step(0, 0, 2'b00, 2'b00);
      step(0, 0, 2'b00, 2'b00);
      first = 0; bfirst = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1, 1, 2'b11, 2'b00);
         if (all_tgt && first == 0) first = n;
         if (b_z2[0] && bfirst == 0) bfirst = n;
      end
      chk("t1_all_tgt_cycle", 32'(first), 32'd12);
      chk("t5_b_z2_cycle", 32'(bfirst), 32'd6);
      chk("t1_hit", 32'(hit), 32'd3);

      // Channel 0 loops forever on i=0, channel 1 escapes.
      step(0, 0, 2'b00, 2'b00);
      firstany = 0; sawall = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1, 1, 2'b10, 2'b00);
         if (any_tgt && firstany == 0) firstany = n;
         if (all_tgt) sawall = 1;
      end
      chk("t2_any_cycle", 32'(firstany), 32'd12);
      chk("t2_all_never", 32'(sawall), 32'd0);

      // Every other cycle stalled doubles the latency.
      step(0, 0, 2'b00, 2'b00);
      first = 0;
      for (int n = 1; n <= 60; n++) begin
         step(1, (n % 2) == 0, 2'b11, 2'b00);
         if (all_tgt && first == 0) first = n;
      end
      chk("t3_all_tgt_cycle", 32'(first), 32'd24);

      // Clear beats stall; hit survives clear but not reset.
      step(1, 0, 2'b11, 2'b01);
      chk("t4_z2_0", 32'(z2[0]), 32'd0);
      chk("t4_hit0", 32'(hit[0]), 32'd1);
      step(0, 0, 2'b00, 2'b00);
      chk("t4_hit_reset", 32'(hit), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         rc[0] = ($urandom_range(0, 31) == 0);
         rc[1] = ($urandom_range(0, 31) == 0);
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, 2'($urandom), rc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/loop_fsm_param.md
# loop_fsm_param

Parametrised, multi-channel successor to the team's 4-bit loop-state benchmark FSM. Each channel walks a fixed state sequence with an input-dependent branch and a 1→2→5→1 loop. A per-channel loop counter makes the target state reachable after a programmable number of loop iterations. Per-channel predicate outputs and aggregate flags serve as property targets for the model-checking flow.

## Interface
Parameters:
- W, 4: state register width; legal range 4..16.
- CH, 2: number of independent channels; minimum 1.
- TGT, 9: target state value; must differ from 0,1,2,5,6,7,8,10 and fit in W bits.
- THR, 2: threshold for the z3 predicate.
- LOOP_MAX, 2: number of 5→1 returns required before escape is allowed.

Ports (clock and reset first):
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- en  in  1  global advance enable.
- i  in  CH  per-channel branch input.
- clr  in  CH  per-channel synchronous clear.
- z1  out  CH  x[c][3] & x[c][0].
- z2  out  CH  x[c] == TGT.
- z3  out  CH  x[c] > THR (unsigned).
- hit  out  CH  sticky: channel has ever reached TGT.
- all_tgt  out  1  &z2.
- any_tgt  out  1  |z2.

## Operation
Per-channel registers:
- x[c]: W-bit state.
- cnt[c]: clog2(LOOP_MAX+1)-bit loop count.
- hit[c]: sticky flag.

Update priority at each posedge, highest first:
1. **Reset.** reset=0 → x=0, cnt=0, hit=0 for all channels.
2. **Clear.** clr[c]=1 → x[c]=0, cnt[c]=0. hit[c] is unchanged. Clear acts regardless of en.
3. **Stall.** en=0 → x, cnt and hit hold.
4. **Transition.** en=1 → x[c] follows the table below.

Transitions (en=1):
- 0→8, 8→10, 10→1, 1→2.
- 2: i=1→5; i=0→6.
- 6→7, 7→5.
- 5:
  - If cnt==LOOP_MAX and i=1 → TGT, cnt←0.
  - Otherwise → 1; cnt increments, saturating at LOOP_MAX.
- TGT: holds until clr.
- 2^W−1 and 2^W−2 → TGT. These states are unreachable from reset and exist for property checks.
- Any other value holds.

Other rules:
- hit[c] is set on any cycle where the registered x[c]==TGT and is cleared only by reset.
- All z*, all_tgt and any_tgt are combinational from registers; there is no input-to-output path.

Reset values of all outputs: z1=0, z2=0, z3=0, hit=0, all_tgt=0, any_tgt=0.

## Timing
- One state step per enabled cycle; i and clr are sampled at posedge.
- From reset release with en=1 and i[c]=1 held, x[c] reaches TGT after 6+3·LOOP_MAX cycles (default 12). The state is 5 at cycle 5+3k, with cnt=k.
- With i[c]=0 held, the loop is 5→1→2→6→7→5 (5 cycles) and TGT is never reached.
- LOOP_MAX=0: the first visit to 5 with i=1 escapes.
- clr and en=0 in the same cycle: clr wins.
- Reset mid-loop: cnt is discarded; the sequence restarts from 0.
- hit is asserted one cycle after z2 first asserts, because it is sampled from the registered z2 condition.

## Structure
- Package loop_fsm_pkg holds:
  - state localparams S0, S1, S2, S5, S6, S7, S8, S10;
  - a next_state function taking (x, i, cnt_at_max, TGT, W).
- Sub-module loop_fsm_chan implements one channel: x, cnt, hit, z1/z2/z3.
- The top generates CH instances of loop_fsm_chan and reduces z2 into all_tgt and any_tgt.

## Test plan
1. Defaults, reset low 2 cycles, then en=1, i=2'b11 → z2=2'b11 and all_tgt=1 at cycle 12; hit=2'b11 at cycle 13.
2. i[0]=0, i[1]=1 held → ch0 cycles 5,1,2,6,7 forever with z2[0]=0; ch1 reaches TGT at cycle 12; any_tgt=1, all_tgt=0.
3. en toggled 0 every other cycle with i=1 → TGT reached at cycle 24; x frozen on every stall cycle.
4. clr[0] pulsed while x[0]=TGT with en=0 → x[0]=0 next cycle; hit[0] stays 1; reset → hit[0]=0.
5. LOOP_MAX=0, W=6, TGT=33 → z2 at cycle 6; z3=1 in states 8, 10, 5, 6, 7 and 33.
6. Force x=2^W−1 via state preload in the formal harness, en=1 → x=TGT next cycle.
